// File: rtl/div_seq_unit_if.sv
// EX-stage <-> sequential divider bundle: request operands, stall/valid status, results.
// The EX stage drives the master side; the divider takes the slave side.
interface div_seq_unit_if #(
  parameter int WIDTH = 32
);
  logic             div_startE;
  logic             div_signedE;
  logic [WIDTH-1:0] src_aE;
  logic [WIDTH-1:0] src_bE;
  logic             flushE;
  logic             div_stallE;
  logic             div_validE;
  logic [WIDTH-1:0] quotientE;
  logic [WIDTH-1:0] remainderE;

  modport master (
    output div_startE, div_signedE, src_aE, src_bE, flushE,
    input  div_stallE, div_validE, quotientE, remainderE
  );

  modport slave (
    input  div_startE, div_signedE, src_aE, src_bE, flushE,
    output div_stallE, div_validE, quotientE, remainderE
  );
endinterface

// File: rtl/div_seq_unit.sv
// Radix-2 restoring divider for MIPS DIV/DIVU, one quotient bit per cycle.
// Valid pulses WIDTH+1 cycles after start; stall is held from start until the result cycle.
module div_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          resetn,
  div_seq_unit_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dq;      // dividend shifts out the top, quotient bits shift in the bottom
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH-1:0] q_r, r_r;
  logic             q_neg, r_neg, dz;

  logic             accept, last;
  logic             neg_a, neg_b;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   pr, pr_sub;
  logic             qbit;
  logic [WIDTH-1:0] rem_nxt, dq_nxt, q_fin, r_fin;

  assign accept = (state == IDLE) && bus.div_startE && !bus.flushE;
  assign last   = (cnt == CW'(WIDTH-1));

  assign neg_a = bus.div_signedE && bus.src_aE[WIDTH-1];
  assign neg_b = bus.div_signedE && bus.src_bE[WIDTH-1];
  assign a_abs = neg_a ? -bus.src_aE : bus.src_aE;
  assign b_abs = neg_b ? -bus.src_bE : bus.src_bE;

  // No borrow out of the trial subtraction means partial remainder >= divisor.
  assign pr      = {rem, dq[WIDTH-1]};
  assign pr_sub  = pr - {1'b0, b_mag};
  assign qbit    = !pr_sub[WIDTH];
  assign rem_nxt = qbit ? pr_sub[WIDTH-1:0] : pr[WIDTH-1:0];
  assign dq_nxt  = {dq[WIDTH-2:0], qbit};

  // Divide-by-zero bypasses sign correction so both modes give all-ones / raw dividend.
  assign q_fin = dz ? {WIDTH{1'b1}} : (q_neg ? -dq_nxt : dq_nxt);
  assign r_fin = dz ? a_raw         : (r_neg ? -rem_nxt : rem_nxt);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC: begin
        if (bus.flushE)  state_nxt = IDLE;
        else if (last)   state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt   <= '0;
      dq    <= '0;
      b_mag <= '0;
      rem   <= '0;
      a_raw <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      dz    <= 1'b0;
      q_r   <= '0;
      r_r   <= '0;
    end else if (accept) begin
      cnt   <= '0;
      dq    <= a_abs;
      b_mag <= b_abs;
      rem   <= '0;
      a_raw <= bus.src_aE;
      q_neg <= bus.div_signedE && (bus.src_aE[WIDTH-1] ^ bus.src_bE[WIDTH-1]);
      r_neg <= neg_a;
      dz    <= (bus.src_bE == '0);
    end else if ((state == CALC) && !bus.flushE) begin
      cnt <= cnt + 1'b1;
      dq  <= dq_nxt;
      rem <= rem_nxt;
      if (last) begin
        q_r <= q_fin;
        r_r <= r_fin;
      end
    end
  end

  assign bus.div_stallE = accept || ((state == CALC) && !bus.flushE);
  assign bus.div_validE = (state == DONE);
  assign bus.quotientE  = q_r;
  assign bus.remainderE = r_r;
endmodule

// File: tb/tb_div_seq_unit.sv
// Directed bench for div_seq_unit: driver queues expected results, a negedge monitor scores each valid pulse.
module tb_div_seq_unit;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  div_seq_unit_if #(.WIDTH(WIDTH)) bus ();

  div_seq_unit #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (resetn === 1'b1 && bus.div_validE === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got valid at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        chk("quotient",    bus.quotientE,  e.q);
        chk("remainder",   bus.remainderE, e.r);
        chk("valid_cycle", 32'(cyc),       32'(e.cyc));
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that ends the result cycle, start still held.
  task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic [31:0] r);
    int   n;
    exp_t e;
    bus.div_startE  = 1'b1;
    bus.div_signedE = sg;
    bus.src_aE      = a;
    bus.src_bE      = b;
    bus.flushE      = 1'b0;
    e.q   = q;
    e.r   = r;
    e.cyc = cyc + 33;
    sb.push_back(e);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.div_stallE === 1'b1) n++;
      else break;
      @(posedge clk);
      #1;
    end
    chk("stall_cycles", 32'(n), 32'd33);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.div_startE = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_quotient"},  bus.quotientE,           32'd0);
    chk({tag, "_remainder"}, bus.remainderE,          32'd0);
    chk({tag, "_valid"},     32'(bus.div_validE),     32'd0);
    chk({tag, "_stall"},     32'(bus.div_stallE),     32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.div_startE  = 1'b0;
    bus.div_signedE = 1'b0;
    bus.src_aE      = '0;
    bus.src_bE      = '0;
    bus.flushE      = 1'b0;
    resetn          = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    resetn = 1'b1;
    @(posedge clk);
    #1;

    do_div(1'b0, 32'd100,        32'd7,          32'd14,         32'd2);          idle(2);
    do_div(1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF);   idle(1);
    do_div(1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1);          idle(1);
    do_div(1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0);          idle(1);
    do_div(1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0);          idle(1);
    do_div(1'b1, 32'hFFFFFFF8,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF8);   idle(1);
    do_div(1'b1, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5);          idle(1);

    // Flush at T10: stall drops at once, no pulse, previous results hold.
    bus.div_startE  = 1'b1;
    bus.div_signedE = 1'b0;
    bus.src_aE      = 32'd100;
    bus.src_bE      = 32'd7;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    bus.flushE = 1'b1;
    @(negedge clk);
    chk("flush_stall", 32'(bus.div_stallE), 32'd0);
    @(posedge clk);
    #1;
    bus.flushE     = 1'b0;
    bus.div_startE = 1'b0;
    @(negedge clk);
    chk("flush_hold_quotient",  bus.quotientE,  32'hFFFFFFFF);
    chk("flush_hold_remainder", bus.remainderE, 32'd5);
    chk("flush_idle_stall",     32'(bus.div_stallE), 32'd0);
    @(posedge clk);
    #1;
    do_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0);
    idle(1);

    // Back-to-back: the second start lands in the cycle after DONE.
    do_div(1'b0, 32'd20, 32'd6, 32'd3, 32'd2);
    do_div(1'b0, 32'd50, 32'd8, 32'd6, 32'd2);
    idle(1);

    // Reset at T15 mid-calculation.
    bus.div_startE  = 1'b1;
    bus.div_signedE = 1'b0;
    bus.src_aE      = 32'd20;
    bus.src_bE      = 32'd6;
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    resetn         = 1'b0;
    bus.div_startE = 1'b0;
    #1;
    chk_zero_outputs("midreset");
    @(posedge clk);
    #1;
    resetn = 1'b1;
    idle(40);
    chk_zero_outputs("postreset");

    chk("pending_results", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
